// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares a single TXD pin between two byte sources. Requester 0 is the CPU
// UART path and requester 1 is the debug/trace path. When the serialiser is
// idle, one requester is chosen by per-byte round-robin arbitration. The
// chosen byte is then sent as an 8N1 or 8N2 frame, LSB first, at a fixed
// baud rate. Each bit lasts CLK_DIV cycles of clk50M.
//
// Parameters
//   CLK_DIV    clk50M cycles per bit (2..65535)
//   STOP_BITS  number of stop bits (1 or 2)
//
// Ports
//   clk50M       system clock, rising edge
//   reset        synchronous active-high reset, highest priority
//   req0_valid   requester 0 has a byte       req0_data  requester 0 byte
//   req0_ready   requester 0 byte accepted this cycle (combinational, IDLE only)
//   req1_valid   requester 1 has a byte       req1_data  requester 1 byte
//   req1_ready   requester 1 byte accepted this cycle (combinational, IDLE only)
//   TXD          registered serial output, idle high
//   busy         high while a frame is in progress
//   grant_id     requester whose byte is currently / was last sent
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int CLK_DIV   = 434,
    parameter int STOP_BITS = 1
) (
    input  logic       clk50M,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       TXD,
    output logic       busy,
    output logic       grant_id
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);
    localparam logic        STOP_LAST = 1'(STOP_BITS - 1);

    state_t      state_r, state_next_s;
    logic [15:0] baud_cnt_r, baud_cnt_next_s;
    logic [2:0]  bit_idx_r, bit_idx_next_s;
    logic        stop_cnt_r, stop_cnt_next_s;
    logic [7:0]  shift_r, shift_next_s;
    logic        last_grant_r, last_grant_next_s;
    logic        grant_id_r, grant_id_next_s;
    logic        txd_r, txd_next_s;
    logic        busy_r;
    logic        ready0_s, ready1_s;
    logic        xfer_s, winner_s, bit_end_s;

    // Round-robin arbitration. Ready is offered only in IDLE and never while
    // reset is held. Under contention, the requester that did not win last
    // time gets ready.
    always_comb begin
        ready0_s = 1'b0;
        ready1_s = 1'b0;
        if (!reset && (state_r == ST_IDLE)) begin
            if (req0_valid && req1_valid) begin
                ready0_s = last_grant_r;
                ready1_s = ~last_grant_r;
            end else begin
                ready0_s = req0_valid;
                ready1_s = req1_valid;
            end
        end else begin
            ready0_s = 1'b0;
            ready1_s = 1'b0;
        end
    end

    assign xfer_s    = (ready0_s & req0_valid) | (ready1_s & req1_valid);
    assign winner_s  = ready1_s & req1_valid;
    assign bit_end_s = (baud_cnt_r == BAUD_LAST);

    // Frame sequencing: next state, baud counter, bit index and shift register
    always_comb begin
        state_next_s      = state_r;
        baud_cnt_next_s   = baud_cnt_r;
        bit_idx_next_s    = bit_idx_r;
        stop_cnt_next_s   = stop_cnt_r;
        shift_next_s      = shift_r;
        last_grant_next_s = last_grant_r;
        grant_id_next_s   = grant_id_r;
        txd_next_s        = 1'b1;
        case (state_r)
            ST_IDLE: begin
                baud_cnt_next_s = 16'd0;
                if (xfer_s) begin
                    state_next_s      = ST_START;
                    shift_next_s      = winner_s ? req1_data : req0_data;
                    grant_id_next_s   = winner_s;
                    last_grant_next_s = winner_s;
                    bit_idx_next_s    = 3'd0;
                    stop_cnt_next_s   = 1'b0;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_next_s    = ST_DATA;
                    baud_cnt_next_s = 16'd0;
                    bit_idx_next_s  = 3'd0;
                end else begin
                    baud_cnt_next_s = baud_cnt_r + 16'd1;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    baud_cnt_next_s = 16'd0;
                    if (bit_idx_r == 3'd7) begin
                        state_next_s    = ST_STOP;
                        stop_cnt_next_s = 1'b0;
                    end else begin
                        shift_next_s   = {1'b0, shift_r[7:1]};
                        bit_idx_next_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    baud_cnt_next_s = baud_cnt_r + 16'd1;
                end
            end
            ST_STOP: begin
                if (bit_end_s) begin
                    baud_cnt_next_s = 16'd0;
                    if (stop_cnt_r == STOP_LAST) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        stop_cnt_next_s = stop_cnt_r + 1'b1;
                    end
                end else begin
                    baud_cnt_next_s = baud_cnt_r + 16'd1;
                end
            end
            default: begin
                state_next_s    = ST_IDLE;
                baud_cnt_next_s = 16'd0;
            end
        endcase

        // TXD is computed from the upcoming state so that the register holds
        // the line level for the cycle the state is actually in.
        case (state_next_s)
            ST_START: txd_next_s = 1'b0;
            ST_DATA:  txd_next_s = shift_next_s[0];
            default:  txd_next_s = 1'b1;
        endcase
    end

    // State, datapath and registered outputs with synchronous reset
    always_ff @(posedge clk50M) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            baud_cnt_r   <= 16'd0;
            bit_idx_r    <= 3'd0;
            stop_cnt_r   <= 1'b0;
            shift_r      <= 8'h00;
            last_grant_r <= 1'b1;
            grant_id_r   <= 1'b0;
            txd_r        <= 1'b1;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            baud_cnt_r   <= baud_cnt_next_s;
            bit_idx_r    <= bit_idx_next_s;
            stop_cnt_r   <= stop_cnt_next_s;
            shift_r      <= shift_next_s;
            last_grant_r <= last_grant_next_s;
            grant_id_r   <= grant_id_next_s;
            txd_r        <= txd_next_s;
            busy_r       <= (state_next_s != ST_IDLE);
        end
    end

    assign req0_ready = ready0_s;
    assign req1_ready = ready1_s;
    assign TXD        = txd_r;
    assign busy       = busy_r;
    assign grant_id   = grant_id_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Bench with two instances, both at CLK_DIV=4: instance 0 uses STOP_BITS=1
// and instance 1 uses STOP_BITS=2.
//
// A frame-position model predicts every output on every cycle. During a frame,
// the bit index is the cycle offset divided by CLK_DIV. Bit 0 is the start bit,
// bits 1..8 are the data, and the remaining bits are stop bits. Outside a
// frame, the model applies round-robin arbitration.
//
// Directed scenarios pin the model with hand-computed literals. A randomized
// phase then exercises both instances.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int D   = 4;
    localparam int SB0 = 1;
    localparam int SB1 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst, v0, v1, r0, r1, txd, busy, gid;
    logic [7:0] d0 [2];
    logic [7:0] d1 [2];

    uart_tx_arbiter #(.CLK_DIV(D), .STOP_BITS(SB0)) dut0 (
        .clk50M(clk), .reset(rst[0]),
        .req0_valid(v0[0]), .req0_data(d0[0]), .req0_ready(r0[0]),
        .req1_valid(v1[0]), .req1_data(d1[0]), .req1_ready(r1[0]),
        .TXD(txd[0]), .busy(busy[0]), .grant_id(gid[0])
    );

    uart_tx_arbiter #(.CLK_DIV(D), .STOP_BITS(SB1)) dut1 (
        .clk50M(clk), .reset(rst[1]),
        .req0_valid(v0[1]), .req0_data(d0[1]), .req0_ready(r0[1]),
        .req1_valid(v1[1]), .req1_data(d1[1]), .req1_ready(r1[1]),
        .TXD(txd[1]), .busy(busy[1]), .grant_id(gid[1])
    );

    int n_checks = 0;
    int n_err    = 0;
    int cyc_n    = 0;

    // ---------------- behavioural model ----------------
    bit   [1:0] m_init = 2'b00;
    bit   [1:0] m_act  = 2'b00;
    int         m_k [2];
    logic [7:0] m_byte [2];
    logic [1:0] m_last, m_gid;
    logic [1:0] e_r0 = 2'b00, e_r1 = 2'b00, e_txd, e_busy;

    function automatic int frame_len(int i);
        return (9 + ((i == 0) ? SB0 : SB1)) * D;
    endfunction

    task automatic chk_bit(string nm, logic act, logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %b, expected %b", nm, cyc_n, act, exp);
        end
    endtask

    task automatic chk_int(string nm, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Predict and compare every output of both instances each cycle
    always @(negedge clk) begin
        int b;
        cyc_n++;
        for (int i = 0; i < 2; i++) begin
            if (m_act[i]) begin
                b = m_k[i] / D;
                e_txd[i]  = (b == 0) ? 1'b0 : ((b <= 8) ? m_byte[i][b-1] : 1'b1);
                e_busy[i] = 1'b1;
                e_r0[i]   = 1'b0;
                e_r1[i]   = 1'b0;
            end else begin
                e_txd[i]  = 1'b1;
                e_busy[i] = 1'b0;
                if (rst[i]) begin
                    e_r0[i] = 1'b0;
                    e_r1[i] = 1'b0;
                end else if (v0[i] && v1[i]) begin
                    e_r0[i] = m_last[i];
                    e_r1[i] = ~m_last[i];
                end else begin
                    e_r0[i] = v0[i];
                    e_r1[i] = v1[i];
                end
            end
            if (m_init[i]) begin
                chk_bit($sformatf("model_txd%0d", i),   txd[i],  e_txd[i]);
                chk_bit($sformatf("model_busy%0d", i),  busy[i], e_busy[i]);
                chk_bit($sformatf("model_ready0_%0d", i), r0[i], e_r0[i]);
                chk_bit($sformatf("model_ready1_%0d", i), r1[i], e_r1[i]);
                chk_bit($sformatf("model_grant%0d", i), gid[i],  m_gid[i]);
            end
        end
    end

    // Advance the model on each clock edge
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst[i]) begin
                m_init[i] <= 1'b1;
                m_act[i]  <= 1'b0;
                m_k[i]    <= 0;
                m_last[i] <= 1'b1;
                m_gid[i]  <= 1'b0;
            end else if (!m_act[i] && ((e_r0[i] && v0[i]) || (e_r1[i] && v1[i]))) begin
                m_act[i]  <= 1'b1;
                m_k[i]    <= 0;
                m_byte[i] <= (e_r1[i] && v1[i]) ? d1[i] : d0[i];
                m_last[i] <= e_r1[i] && v1[i];
                m_gid[i]  <= e_r1[i] && v1[i];
            end else if (m_act[i]) begin
                if (m_k[i] + 1 == frame_len(i)) m_act[i] <= 1'b0;
                m_k[i] <= m_k[i] + 1;
            end
        end
    end

    // ---------------- directed helpers ----------------
    logic cap_txd [0:199];
    logic cap_busy[0:199];
    logic cap_r0  [0:199];
    logic cap_r1  [0:199];
    logic cap_gid [0:199];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(int i, int n);
        rst[i] = 1'b1;
        repeat (n) tick();
        rst[i] = 1'b0;
    endtask

    // Sample n cycles of instance i; if clr, drop a valid once it is accepted
    task automatic capture(int i, int n, bit clr);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            cap_txd[c]  = txd[i];
            cap_busy[c] = busy[i];
            cap_r0[c]   = r0[i];
            cap_r1[c]   = r1[i];
            cap_gid[c]  = gid[i];
            tick();
            if (clr && cap_r0[c]) v0[i] = 1'b0;
            if (clr && cap_r1[c]) v1[i] = 1'b0;
        end
    endtask

    function automatic int sum_busy(int lo, int hi);
        int s = 0;
        for (int c = lo; c <= hi; c++) s += int'(cap_busy[c]);
        return s;
    endfunction

    function automatic logic [7:0] decode(int base);
        logic [7:0] r;
        for (int b = 0; b < 8; b++) r[b] = cap_txd[base + 4 * b];
        return r;
    endfunction

    initial begin
        logic [9:0] pat;
        int mism, s, first;
        int acc_c[$];
        int acc_id[$];

        rst = 2'b11; v0 = 2'b00; v1 = 2'b00;
        for (int i = 0; i < 2; i++) begin d0[i] = 8'h00; d1[i] = 8'h00; end
        tick(); tick();
        rst = 2'b00;

        // 1: req0 sends 0xA5 -> 0,1,0,1,0,0,1,0,1,1 with 4 cycles per bit
        pat = 10'b1101001010;
        v0[0] = 1'b1; d0[0] = 8'hA5;
        capture(0, 46, 1'b1);
        s = 0;
        for (int c = 0; c < 46; c++) s += int'(cap_r0[c]);
        chk_int("t1_ready_cycles", s, 1);
        chk_bit("t1_ready_first", cap_r0[0], 1'b1);
        chk_int("t1_busy_cycles", sum_busy(0, 45), 40);
        mism = 0;
        for (int c = 1; c <= 40; c++) if (cap_txd[c] !== pat[(c - 1) / 4]) mism++;
        chk_int("t1_txd_mismatch_samples", mism, 0);
        chk_bit("t1_grant", cap_gid[1], 1'b0);

        // 2: both continuously valid -> alternate 0,1,0,1 with 41-cycle period
        do_reset(0, 2);
        v0[0] = 1'b1; d0[0] = 8'h11; v1[0] = 1'b1; d1[0] = 8'h22;
        capture(0, 170, 1'b0);
        v0[0] = 1'b0; v1[0] = 1'b0;
        for (int c = 0; c < 170; c++) begin
            if (cap_r0[c]) begin acc_c.push_back(c); acc_id.push_back(0); end
            if (cap_r1[c]) begin acc_c.push_back(c); acc_id.push_back(1); end
        end
        chk_int("t2_accepts", acc_c.size(), 5);
        if (acc_c.size() >= 5) begin
            for (int j = 0; j < 4; j++) begin
                chk_int($sformatf("t2_id%0d", j), acc_id[j], j % 2);
                chk_int($sformatf("t2_period%0d", j), acc_c[j+1] - acc_c[j], 41);
                chk_bit($sformatf("t2_gap_txd%0d", j), cap_txd[acc_c[j+1]], 1'b1);
                chk_bit($sformatf("t2_gap_busy%0d", j), cap_busy[acc_c[j+1]], 1'b0);
                chk_bit($sformatf("t2_grant%0d", j), cap_gid[acc_c[j] + 1], 1'(j % 2));
                chk_int($sformatf("t2_byte%0d", j), int'(decode(acc_c[j] + 7)),
                        (j % 2 == 0) ? 32'h11 : 32'h22);
            end
        end

        // 3: only req1 -> immediate grant; req0 arriving mid-frame waits for IDLE
        do_reset(0, 2);
        v1[0] = 1'b1; d1[0] = 8'h3C;
        capture(0, 10, 1'b1);
        chk_bit("t3_ready1", cap_r1[0], 1'b1);
        chk_bit("t3_grant1", cap_gid[1], 1'b1);
        v0[0] = 1'b1; d0[0] = 8'h5A;
        capture(0, 60, 1'b1);
        first = -1;
        for (int c = 59; c >= 0; c--) if (cap_r0[c]) first = c;
        chk_int("t3_req0_accept_offset", first, 31);
        chk_bit("t3_grant0", cap_gid[32], 1'b0);

        // 4: reset during DATA bit 3 of 0xFF aborts the frame
        do_reset(0, 2);
        v0[0] = 1'b1; d0[0] = 8'hFF;
        capture(0, 18, 1'b1);
        rst[0] = 1'b1;
        v0[0] = 1'b1; d0[0] = 8'h00; v1[0] = 1'b1; d1[0] = 8'h55;
        capture(0, 3, 1'b0);
        chk_bit("t4_busy_before", cap_busy[0], 1'b1);
        for (int c = 1; c < 3; c++) begin
            chk_bit($sformatf("t4_txd%0d", c),  cap_txd[c],  1'b1);
            chk_bit($sformatf("t4_busy%0d", c), cap_busy[c], 1'b0);
            chk_bit($sformatf("t4_r0_%0d", c),  cap_r0[c],   1'b0);
            chk_bit($sformatf("t4_r1_%0d", c),  cap_r1[c],   1'b0);
        end
        rst[0] = 1'b0;
        capture(0, 2, 1'b1);
        chk_bit("t4_req0_wins", cap_r0[0], 1'b1);
        chk_bit("t4_req1_waits", cap_r1[0], 1'b0);
        chk_bit("t4_grant", cap_gid[1], 1'b0);
        capture(0, 45, 1'b1);
        chk_int("t4_byte", int'(decode(5)), 32'h00);

        // 5: two stop bits -> 44-cycle frame, stop phase high for 8 cycles
        do_reset(1, 2);
        v0[1] = 1'b1; d0[1] = 8'h80;
        capture(1, 50, 1'b1);
        chk_int("t5_busy_cycles", sum_busy(0, 49), 44);
        mism = 0;
        for (int c = 37; c <= 44; c++) if (cap_txd[c] !== 1'b1) mism++;
        chk_int("t5_stop_low_samples", mism, 0);
        mism = 0;
        for (int c = 29; c <= 32; c++) if (cap_txd[c] !== 1'b0) mism++;
        chk_int("t5_bit6_high_samples", mism, 0);
        chk_bit("t5_bit7", cap_txd[34], 1'b1);

        // 6: one-cycle valid pulse while busy is ignored
        do_reset(0, 2);
        v0[0] = 1'b1; d0[0] = 8'h0F;
        capture(0, 12, 1'b1);
        v0[0] = 1'b1; d0[0] = 8'hC3;
        capture(0, 1, 1'b0);
        chk_bit("t6_no_ready", cap_r0[0], 1'b0);
        v0[0] = 1'b0;
        capture(0, 60, 1'b0);
        chk_int("t6_busy_remaining", sum_busy(0, 59), 28);

        // Randomized traffic on both instances, following the valid/ready protocol
        rst = 2'b11; tick(); tick(); rst = 2'b00;
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            tick();
            for (int i = 0; i < 2; i++) begin
                if (v0[i] && e_r0[i]) v0[i] = 1'b0;
                else if (v0[i] && ($urandom_range(0, 19) == 0)) v0[i] = 1'b0;
                else if (!v0[i] && ($urandom_range(0, 7) == 0)) begin
                    v0[i] = 1'b1; d0[i] = 8'($urandom);
                end
                if (v1[i] && e_r1[i]) v1[i] = 1'b0;
                else if (v1[i] && ($urandom_range(0, 19) == 0)) v1[i] = 1'b0;
                else if (!v1[i] && ($urandom_range(0, 7) == 0)) begin
                    v1[i] = 1'b1; d1[i] = 8'($urandom);
                end
                rst[i] = ($urandom_range(0, 699) == 0);
            end
        end
        rst = 2'b00; v0 = 2'b00; v1 = 2'b00;
        repeat (60) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the SoC's single TXD pin between two byte sources: requester 0 is the CPU UART path and requester 1 is the debug/trace path.
- Arbitrates round-robin per byte, then serialises the granted byte as 8N1 (or 8N2) at a fixed baud set by a clock divider.
- Sits between the APB UART/trace sources and the top-level TXD output in ARM_SOC_TOP.

Parameters:
- CLK_DIV, 434, clk50M cycles per bit (50 MHz / 115200); legal range 2..65535.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk50M  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has a byte.
- req0_data  input  8  requester 0 byte.
- req0_ready  output  1  requester 0 byte accepted this cycle.
- req1_valid  input  1  requester 1 has a byte.
- req1_data  input  8  requester 1 byte.
- req1_ready  output  1  requester 1 byte accepted this cycle.
- TXD  output  1  serial line; idle high.
- busy  output  1  frame in progress (state != IDLE).
- grant_id  output  1  requester whose byte is currently/last sent.

Behaviour:
- Reset values:
  - TXD=1, busy=0, grant_id=0, req0_ready=0, req1_ready=0.
  - state=IDLE, last_grant=1, so requester 0 wins the first contention.
  - Reset has priority over everything.
  - Reset mid-frame aborts the frame: TXD returns to 1 the next cycle, and the partially sent byte is dropped and not re-sent.
- States: IDLE -> START -> DATA -> STOP -> IDLE.
- IDLE, arbitration (combinational):
  - Only req0_valid: req0_ready=1.
  - Only req1_valid: req1_ready=1.
  - Both valid: the requester != last_grant gets ready.
  - At most one ready is high in any cycle.
  - ready is high only in IDLE.
- Handshake:
  - Transfer occurs when valid && ready.
  - On transfer, the byte is latched into the shift register, grant_id and last_grant are set to the winner, and state goes to START on the next cycle.
  - Requesters hold valid and data stable until ready. Dropping valid before ready is allowed; nothing is sent.
- Bit timing:
  - A baud counter counts 0..CLK_DIV-1 and resets to 0 on each state/bit advance.
  - Every bit, including start and each stop bit, lasts exactly CLK_DIV cycles.
- START: TXD=0 for CLK_DIV cycles, then DATA with bit index 0.
- DATA:
  - TXD = shift[0], LSB first.
  - After CLK_DIV cycles, shift right and increment the 3-bit index.
  - After bit 7, go to STOP.
- STOP: TXD=1 for STOP_BITS*CLK_DIV cycles, then IDLE.
- Latency:
  - TXD falls on the cycle after the accepting edge.
  - Frame length is (9+STOP_BITS)*CLK_DIV cycles.
  - Back-to-back frames have exactly one IDLE cycle between them: the minimum byte period is (9+STOP_BITS)*CLK_DIV+1 cycles.
- TXD is a registered output, so it is glitch-free.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1,...
- busy is high from the first START cycle through the last STOP cycle.

Test Plan:
1. CLK_DIV=4, STOP_BITS=1, reset for 2 cycles, then req0 sends 0xA5:
   - TXD bit sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles.
   - req0_ready is high for 1 cycle; busy is high for 40 cycles; grant_id=0.
2. req0 and req1 both valid continuously, data 0x11 and 0x22:
   - Frames appear in order 0x11, 0x22, 0x11, 0x22; grant_id alternates 0,1,0,1.
   - The gap between frames is exactly 1 idle cycle (TXD=1).
3. Only req1 valid with 0x3C while req0 is idle:
   - req1 is accepted immediately, grant_id=1.
   - req0 asserts mid-frame: its ready stays 0 until IDLE, then it is accepted.
4. Reset asserted during DATA bit 3 of 0xFF:
   - The next cycle TXD=1, busy=0, ready=0, and no further frame bits are sent.
   - After deassertion, a new req0 byte 0x00 transmits correctly and requester 0 wins contention.
5. STOP_BITS=2, CLK_DIV=4, send 0x80: the stop phase is high for 8 cycles; the total frame is 44 cycles.
6. req0_valid pulsed for 1 cycle while busy: no ready, the byte is not sent, and TXD stays idle after the current frame.
